lvds_tx_serializer: RTL and testbench
=====================================

# lvds_tx_serializer

Fabric-side LVDS transmit serializer: accepts parallel words over a valid/ready stream and emits them MSB-first as two bits per clock on the DDR output pair of a differential IO cell configured as an LVDS output. It is the transmit counterpart of the LVDS input path: the IO cell drives bit pairs on the rising and falling edges of the same clock. Between data words it emits fixed idle or training words so a remote receiver can find word alignment. Output enable to the pad is sequenced so the link only drives during whole words.

## Interface
- DATA_W, 8, word width; even, 4..32; one word occupies DATA_W/2 clocks
- TRAIN_WORD, 8'hF0, DATA_W-bit word repeated while `train` is high (alignment pattern)
- IDLE_WORD, 8'h00, DATA_W-bit word sent when enabled with no data pending
- clk  in  1  single clock, also feeds IO cell OUTPUTCLK
- rst  in  1  reset, synchronous, active-high
- en  in  1  link enable; sampled only at word boundaries
- train  in  1  send TRAIN_WORD instead of data/idle; sampled at word boundaries
- s_data  in  DATA_W  word to send
- s_valid  in  1  s_data valid
- s_ready  out  1  word accepted this cycle when s_valid && s_ready
- dout0  out  1  bit for first half-cycle, to IO cell DOUT0
- dout1  out  1  bit for second half-cycle, to IO cell DOUT1
- oe  out  1  pad drive enable, to IO cell OUTPUTENABLE, active-high

## Operation
- Registers: DATA_W shift register, slot counter `slot` (0..DATA_W/2-1), state OFF/ON.
- Word boundary: cycle where slot == DATA_W/2-1. In OFF, slot is held at DATA_W/2-1, so every cycle is a boundary.
- At each boundary, next word is chosen by priority:
  - en=0: go OFF
  - else train=1: TRAIN_WORD
  - else s_valid=1: s_data (handshake)
  - else: IDLE_WORD
- Loading a word enters ON and sets slot=0.
- s_ready = !rst && boundary && en && !train. It is derived from registered state plus en/train, never from s_valid.
- Each ON cycle outputs dout0 = word[DATA_W-1-2*slot] and dout1 = word[DATA_W-2-2*slot], i.e. MSB first, and increments slot.
- en or train changes mid-word take effect only at the next boundary; a word in flight always completes.
- OFF: oe=0, dout0=dout1=0.
- No inversion for the N leg; the IO cell generates it.

## Timing
- dout0, dout1 and oe are registered. A word loaded at boundary cycle N drives its first pair in N+1 and its last pair in N+DATA_W/2.
- Back-to-back words have no gap. Continuous s_valid gives s_ready once every DATA_W/2 cycles.
- Enable from OFF: en sampled high in cycle N → oe=1 and first pair in N+1.
- Disable: en low at boundary N (the last pair of the current word is output in cycle N) → oe=0, dout0=dout1=0 in N+1.
- Reset values (cycle after rst sampled high): state OFF, slot=DATA_W/2-1, oe=0, dout0=0, dout1=0. s_ready=0 while rst=1.
- Reset mid-word aborts the word immediately, with no completion. A partially sent word is not replayed.
- Simultaneous train and s_valid at a boundary: train wins, s_ready=0, and the data word is held by the source.

## Configuration
- LVDS_TX_MARK_EN defined: adds output ports `tx_sof` (1 bit) and `tx_kind` (2 bits), both registered and aligned with dout0/dout1.
  - tx_sof=1 in the cycle carrying slot 0 of any word.
  - tx_kind is 0 for idle, 1 for train, 2 for data; it is held for the whole word.
  - Reset and OFF values: tx_sof=0, tx_kind=0.
- Not defined: both ports are absent. Serializer behaviour is identical.

## Test plan
- Reset: rst=1 for 3 cycles with en=1 → oe=0, dout0=dout1=0, s_ready=0. Release with en=0 → outputs stay 0 and s_ready stays 0.
- Single word: en=1, s_valid=1, s_data=8'hC6 at cycle 0 → s_ready=1 in cycle 0. (dout0,dout1) in cycles 1..4 = (1,1),(0,0),(0,1),(1,0); oe=1 from cycle 1.
- Back-to-back: 8'hC6 then 8'h3A, valid held → s_ready in cycles 0 and 4. Cycles 5..8 = (0,0),(1,1),(1,0),(1,0), with no gap.
- Idle: en=1, s_valid=0 → IDLE_WORD 8'h00 repeated, s_ready=1 every 4th cycle. Assert s_valid mid-word → accepted at the next boundary only.
- Train: train=1 with s_valid=1 → pairs (1,1),(1,1),(0,0),(0,0) repeating and s_ready=0. Drop train mid-word → the current TRAIN_WORD completes and the data loads at the next boundary.
- Disable/abort: drop en in slot 1 of a data word → the word completes and oe=0 in the cycle after its last pair. Assert rst in slot 1 → next cycle oe=0, dout0=dout1=0.

Source files
------------

// File: rtl/lvds_tx_serializer.sv
// lvds_tx_serializer: MSB-first 2-bit-per-clock DDR serializer with idle/training words and word-aligned output enable.
// Define LVDS_TX_MARK_EN to add tx_sof/tx_kind word markers aligned with dout0/dout1.
module lvds_tx_serializer #(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] TRAIN_WORD = 8'hF0,
  parameter logic [DATA_W-1:0] IDLE_WORD = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              train,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dout0,
  output logic              dout1,
`ifdef LVDS_TX_MARK_EN
  output logic              tx_sof,
  output logic [1:0]        tx_kind,
`endif
  output logic              oe
);
  localparam int H = DATA_W / 2;
  localparam int SW = $clog2(H);
  localparam logic [SW-1:0] LAST = SW'(H - 1);
  typedef enum logic {OFF, ON} state_t;
  state_t state;
  logic [SW-1:0] slot;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] next_word;
  logic boundary;
  assign boundary = state == OFF || slot == LAST;
  assign s_ready = !rst && boundary && en && !train;
  always_comb next_word = train ? TRAIN_WORD : s_valid ? s_data : IDLE_WORD;
  // sh holds the not-yet-sent pairs of the word in flight, MSB aligned
  always_ff @(posedge clk) begin
    if (rst || (boundary && !en)) begin
      state <= OFF;
      slot  <= LAST;
      sh    <= '0;
      dout0 <= 1'b0;
      dout1 <= 1'b0;
      oe    <= 1'b0;
    end else if (boundary) begin
      state <= ON;
      slot  <= '0;
      dout0 <= next_word[DATA_W-1];
      dout1 <= next_word[DATA_W-2];
      sh    <= {next_word[DATA_W-3:0], 2'b00};
      oe    <= 1'b1;
    end else begin
      slot  <= slot + 1'b1;
      dout0 <= sh[DATA_W-1];
      dout1 <= sh[DATA_W-2];
      sh    <= {sh[DATA_W-3:0], 2'b00};
    end
  end
`ifdef LVDS_TX_MARK_EN
  always_ff @(posedge clk) begin
    if (rst || (boundary && !en)) begin
      tx_sof  <= 1'b0;
      tx_kind <= 2'd0;
    end else if (boundary) begin
      tx_sof  <= 1'b1;
      tx_kind <= train ? 2'd1 : s_valid ? 2'd2 : 2'd0;
    end else begin
      tx_sof  <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_lvds_tx_serializer.sv
// tb_lvds_tx_serializer: table-driven per-cycle checks of s_ready/oe/dout plus a streaming-rate sequence.
module tb_lvds_tx_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic train = 1'b0;
  logic s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, dout0, dout1, oe;
`ifdef LVDS_TX_MARK_EN
  logic tx_sof;
  logic [1:0] tx_kind;
`endif
  int n_chk = 0;
  int n_fail = 0;

  lvds_tx_serializer #(.DATA_W(8), .TRAIN_WORD(8'hF0), .IDLE_WORD(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .train(train), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dout0(dout0), .dout1(dout1),
`ifdef LVDS_TX_MARK_EN
    .tx_sof(tx_sof), .tx_kind(tx_kind),
`endif
    .oe(oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, train, valid;
    logic [7:0] data;
    logic ready, oe, d0, d1;
  } vec_t;
  vec_t vec [36];

  task automatic chk(input string nm, input int row, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b expected %b", nm, row, got, exp);
    end
  endtask

  initial begin
    int rdy_cnt;
    vec = '{
      // rst held with en=1
      '{1,1,0,1,8'hC6, 0,0,0,0}, '{1,1,0,1,8'hC6, 0,0,0,0}, '{1,1,0,1,8'hC6, 0,0,0,0},
      // released with en=0
      '{0,0,0,1,8'hC6, 0,0,0,0}, '{0,0,0,1,8'hC6, 0,0,0,0},
      // C6 then 3A back to back
      '{0,1,0,1,8'hC6, 1,0,0,0}, '{0,1,0,1,8'h3A, 0,1,1,1}, '{0,1,0,1,8'h3A, 0,1,0,0},
      '{0,1,0,1,8'h3A, 0,1,0,1}, '{0,1,0,1,8'h3A, 1,1,1,0}, '{0,1,0,0,8'h3A, 0,1,0,0},
      '{0,1,0,0,8'h3A, 0,1,1,1}, '{0,1,0,0,8'h3A, 0,1,1,0},
      // idle word, then s_valid raised mid-word
      '{0,1,0,0,8'h00, 1,1,1,0}, '{0,1,0,1,8'hC6, 0,1,0,0}, '{0,1,0,1,8'hC6, 0,1,0,0},
      '{0,1,0,1,8'hC6, 0,1,0,0}, '{0,1,0,1,8'hC6, 1,1,0,0},
      // train wins over valid data
      '{0,1,1,1,8'h3A, 0,1,1,1}, '{0,1,1,1,8'h3A, 0,1,0,0}, '{0,1,1,1,8'h3A, 0,1,0,1},
      '{0,1,1,1,8'h3A, 0,1,1,0}, '{0,1,1,1,8'h3A, 0,1,1,1}, '{0,1,1,1,8'h3A, 0,1,1,1},
      '{0,1,0,1,8'h3A, 0,1,0,0}, '{0,1,0,1,8'h3A, 1,1,0,0},
      // en dropped in slot 1 of 3A
      '{0,1,0,0,8'h00, 0,1,0,0}, '{0,0,0,0,8'h00, 0,1,1,1}, '{0,0,0,0,8'h00, 0,1,1,0},
      '{0,0,0,0,8'h00, 0,1,1,0}, '{0,0,0,0,8'h00, 0,0,0,0},
      // reset in slot 1 of C6
      '{0,1,0,1,8'hC6, 1,0,0,0}, '{0,1,0,0,8'hC6, 0,1,1,1}, '{1,1,0,0,8'hC6, 0,1,0,0},
      '{0,0,0,0,8'h00, 0,0,0,0}, '{0,0,0,0,8'h00, 0,0,0,0}
    };
    @(negedge clk);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      rst = vec[i].rst; en = vec[i].en; train = vec[i].train;
      s_valid = vec[i].valid; s_data = vec[i].data;
      #1;
      chk("s_ready", i, s_ready, vec[i].ready);
      chk("oe", i, oe, vec[i].oe);
      chk("dout0", i, dout0, vec[i].d0);
      chk("dout1", i, dout1, vec[i].d1);
    end
    // continuous valid from OFF: one accept per word and no oe gap
    rdy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      en = 1'b1; s_valid = 1'b1; s_data = 8'(8'hA0 + c);
      #1;
      if (s_ready) rdy_cnt++;
      if (c > 0) chk("stream_oe", 100 + c, oe, 1'b1);
      if (c % 4 == 0) chk("stream_ready", 100 + c, s_ready, 1'b1);
    end
    n_chk++;
    if (rdy_cnt != 3) begin
      n_fail++;
      $display("FAIL stream_count: got %0d accepts expected 3", rdy_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
